pipe_seg_skid: RTL and testbench
================================

Name: pipe_seg_skid

Overview:
Parametrised pipeline segment register for the pipeline stage boundaries (id/ex, ex/ec, ec/wb).
- Generalises the fixed-field segment registers into one block.
- Carries an opaque DW-bit payload under a valid/ready handshake.
- Keeps the existing stall/refresh semantics.
- Adds an optional skid entry so that in_ready is driven from a flop, which breaks the backward ready path between stages.

Parameters:
DW, 32, payload width in bits (>=1); the stage packs pc/inst/ctrl fields into it.
SKID, 1, 1 = two-entry skid (registered in_ready); 0 = single entry (in_ready depends combinationally on out_ready).

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous active-low reset.
stall  in  1  global hold; freezes all transfers this cycle.
refresh  in  1  synchronous flush (exception/eret); discards all held entries.
in_valid  in  1  upstream payload valid.
in_ready  out  1  segment can accept.
in_data  in  DW  upstream payload.
out_valid  out  1  downstream payload valid.
out_ready  in  1  downstream accepts.
out_data  out  DW  payload to next stage.
occupancy  out  2  number of held entries (0..2).

Behaviour:
Handshake gating:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- in_ready and out_valid are both forced to 0 while stall=1 or refresh=1. No transfer occurs in those cycles.

State machine (state reg, storage main_q and skid_q):
- EMPTY: out_valid=0, in_ready=1. in_fire -> ONE, main_q<=in_data.
- ONE: out_valid=1, out_data=main_q, in_ready=1.
  - in_fire & out_fire -> ONE, main_q<=in_data.
  - in_fire & !out_fire -> FULL, skid_q<=in_data.
  - out_fire & !in_fire -> EMPTY.
- FULL (SKID=1 only): in_ready=0, out_data=main_q. out_fire -> ONE, main_q<=skid_q.

SKID=0:
- FULL is unreachable.
- in_ready = (state==EMPTY) | out_ready.
- In ONE, in_fire & !out_fire cannot occur.

Ordering and latency:
- Strict FIFO ordering; no payload is dropped or duplicated.
- Latency is 1 cycle: a payload accepted at edge N is presented on out_data after edge N.
- Throughput is 1 per cycle when out_ready=1.

Refresh:
- Synchronous, and takes priority over in_fire/out_fire and stall.
- Next state is EMPTY, main_q=skid_q=0.
- An in_valid payload presented in the refresh cycle is not accepted.

Stall:
- State and storage are held; out_data stays stable.
- refresh during stall still flushes.

Reset (resetn=0, asynchronous): state=EMPTY, main_q=0, skid_q=0, out_valid=0, in_ready=0 while asserted, occupancy=0.
- Reset mid-transfer discards the payload.
- in_ready rises the first cycle after deassertion.

out_data when out_valid=0 equals main_q, which is 0 after reset or refresh. The downstream stage must not rely on it.

occupancy: EMPTY=0, ONE=1, FULL=2.

Optional Feature:
Macro SEG_PERF_EN.
- Defined: adds outputs perf_full_cyc[31:0] and perf_bubble_cyc[31:0].
  - perf_full_cyc counts cycles with out_valid & !out_ready & !stall (backpressure).
  - perf_bubble_cyc counts cycles with !out_valid & out_ready & !stall (bubbles).
  - Both saturate at 32'hFFFFFFFF.
  - Both are cleared only by resetn; refresh does not clear them.
- Undefined: these ports and counters do not exist; the datapath behaves identically.

Decomposition:
- Package pipe_seg_pkg holds:
  - seg_state_e typedef (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - localparam PERF_W=32;
  - per-stage payload width constants (e.g. EC_WB_DW).
- One natural sub-module, pipe_seg_perf: the two saturating counters, instantiated only under SEG_PERF_EN.

Test Plan:
- SKID=1, DW=32, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each; occupancy stays 1; in_ready stays 1.
- SKID=1: send A=0xAAAA0000, then B=0x0000BBBB with out_ready=0 -> occupancy 2, in_ready=0. Raise out_ready -> A then B on consecutive cycles, occupancy 2->1->0.
- FULL state, assert refresh together with out_ready=1 and in_valid=1 (C=0xC) -> next cycle occupancy=0, out_valid=0, out_data=0; C is not delivered.
- ONE state holding 0x5; hold stall=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, payload retained. Release -> 0x5 delivered once.
- Drop resetn asynchronously (mid-cycle) while in FULL -> outputs go to 0 immediately, before the next edge. After deassertion, in_ready=1 and occupancy=0.
- SKID=0, SEG_PERF_EN defined: 4 cycles of out_ready=0 with valid data held, then 3 idle cycles with out_ready=1 -> perf_full_cyc=4, perf_bubble_cyc=3; in_ready tracks out_ready combinationally.

Source files
------------

// File: rtl/pipe_seg_skid_pkg.sv
// ============================================================================
// pipe_seg_pkg : shared types and widths for the pipeline segment register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pipe_seg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } seg_state_e;

  localparam int PERF_W = 32;

  // Per-boundary payload widths (pc + inst + ctrl packing)
  localparam int ID_EX_DW = 32 + 32 + 24;
  localparam int EX_EC_DW = 32 + 32 + 16;
  localparam int EC_WB_DW = 32 + 32 + 8;

endpackage

`default_nettype wire

// File: rtl/pipe_seg_skid_if.sv
// ============================================================================
// pipe_seg_skid_if : valid/ready handshake bundle across one segment boundary
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface pipe_seg_skid_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  // slave: the segment itself; master: the surrounding stages
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/pipe_seg_skid_perf.sv
// ============================================================================
// pipe_seg_perf : saturating backpressure / bubble cycle counters
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_seg_perf
  import pipe_seg_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              i_full_evt,
  input  wire logic              i_bubble_evt,
  output logic      [PERF_W-1:0] o_full_cyc,
  output logic      [PERF_W-1:0] o_bubble_cyc
);

  logic [PERF_W-1:0] r_full_cyc;
  logic [PERF_W-1:0] r_bubble_cyc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_full_cyc   <= '0;
      r_bubble_cyc <= '0;
    end else begin
      if (i_full_evt && (r_full_cyc != {PERF_W{1'b1}}))
        r_full_cyc <= r_full_cyc + 1'b1;
      if (i_bubble_evt && (r_bubble_cyc != {PERF_W{1'b1}}))
        r_bubble_cyc <= r_bubble_cyc + 1'b1;
    end
  end

  assign o_full_cyc   = r_full_cyc;
  assign o_bubble_cyc = r_bubble_cyc;

endmodule

`default_nettype wire

// File: rtl/pipe_seg_skid.sv
// ============================================================================
// pipe_seg_skid : parametrised pipeline segment register with optional skid
// Optional feature macro: SEG_PERF_EN (adds perf counters)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_seg_skid
  import pipe_seg_pkg::*;
#(
  parameter int DW   = 32,
  parameter bit SKID = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        i_stall,
  input  wire logic        i_refresh,
  pipe_seg_skid_if.slave   bus,
  output logic      [1:0]  o_occupancy
`ifdef SEG_PERF_EN
  ,
  output logic [PERF_W-1:0] o_perf_full_cyc,
  output logic [PERF_W-1:0] o_perf_bubble_cyc
`endif
);

  seg_state_e    r_state;
  seg_state_e    w_state_nxt;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic [DW-1:0] w_main_nxt;
  logic [DW-1:0] w_skid_nxt;
  logic          r_live;
  logic          w_go;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_in_fire;
  logic          w_out_fire;

  // r_live holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_go        = !i_stall && !i_refresh;

    case (r_state)
      EMPTY: w_in_ready = w_go && r_live;
      ONE: begin
        w_out_valid = w_go;
        w_in_ready  = w_go && (SKID ? 1'b1 : bus.out_ready);
      end
      FULL:    w_out_valid = w_go;
      default: ;
    endcase

    w_in_fire  = bus.in_valid && w_in_ready;
    w_out_fire = w_out_valid && bus.out_ready;

    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ONE;
          w_main_nxt  = bus.in_data;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = bus.in_data;
        end else if (w_in_fire && SKID) begin
          w_state_nxt = FULL;
          w_skid_nxt  = bus.in_data;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt = ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase

    if (i_refresh) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign o_occupancy   = r_state;

`ifdef SEG_PERF_EN
  pipe_seg_perf u_perf (
    .clk          (clk),
    .resetn       (resetn),
    .i_full_evt   (w_out_valid && !bus.out_ready && !i_stall),
    .i_bubble_evt (!w_out_valid && bus.out_ready && !i_stall),
    .o_full_cyc   (o_perf_full_cyc),
    .o_bubble_cyc (o_perf_bubble_cyc)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_seg_skid.sv
// ============================================================================
// tb_pipe_seg_skid : directed bench for pipe_seg_skid (SKID=1 and SKID=0)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pipe_seg_skid;

  logic clk;
  logic resetn;
  logic stall_a, refresh_a;
  logic stall_b, refresh_b;
  logic [1:0] occ_a, occ_b;
  int n_run;
  int n_fail;

  pipe_seg_skid_if #(.DW(32)) bus_a ();
  pipe_seg_skid_if #(.DW(32)) bus_b ();

`ifdef SEG_PERF_EN
  logic [31:0] pf_full_a, pf_bub_a, pf_full_b, pf_bub_b;
`endif

  pipe_seg_skid #(.DW(32), .SKID(1'b1)) u_a (
    .clk         (clk),
    .resetn      (resetn),
    .i_stall     (stall_a),
    .i_refresh   (refresh_a),
    .bus         (bus_a),
    .o_occupancy (occ_a)
`ifdef SEG_PERF_EN
    ,
    .o_perf_full_cyc   (pf_full_a),
    .o_perf_bubble_cyc (pf_bub_a)
`endif
  );

  pipe_seg_skid #(.DW(32), .SKID(1'b0)) u_b (
    .clk         (clk),
    .resetn      (resetn),
    .i_stall     (stall_b),
    .i_refresh   (refresh_b),
    .bus         (bus_b),
    .o_occupancy (occ_b)
`ifdef SEG_PERF_EN
    ,
    .o_perf_full_cyc   (pf_full_b),
    .o_perf_bubble_cyc (pf_bub_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    resetn = 1'b0;
    stall_a = 1'b0; refresh_a = 1'b0;
    stall_b = 1'b0; refresh_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_occ", {30'd0, occ_a}, 32'd0);
    chk("rst_ovalid", {31'd0, bus_a.out_valid}, 32'd0);
    chk("rst_iready", {31'd0, bus_a.in_ready}, 32'd0);
    chk("rst_odata", bus_a.out_data, 32'd0);
    resetn = 1'b1;
    step();
    chk("post_rst_iready", {31'd0, bus_a.in_ready}, 32'd1);

    // streaming at full throughput
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus_a.in_data = i;
      step();
      chk("stream_data", bus_a.out_data, i);
      chk("stream_occ", {30'd0, occ_a}, 32'd1);
      chk("stream_iready", {31'd0, bus_a.in_ready}, 32'd1);
    end
    bus_a.in_valid = 1'b0;
    step();
    chk("stream_drain_occ", {30'd0, occ_a}, 32'd0);

    // fill skid, then drain in order
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 32'hAAAA0000;
    step();
    bus_a.in_data   = 32'h0000BBBB;
    step();
    chk("full_occ", {30'd0, occ_a}, 32'd2);
    chk("full_iready", {31'd0, bus_a.in_ready}, 32'd0);
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    #1;
    chk("drain_a", bus_a.out_data, 32'hAAAA0000);
    step();
    chk("drain_b", bus_a.out_data, 32'h0000BBBB);
    chk("drain_occ1", {30'd0, occ_a}, 32'd1);
    step();
    chk("drain_occ0", {30'd0, occ_a}, 32'd0);

    // refresh from FULL beats out_ready and in_valid
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 32'h11;
    step();
    bus_a.in_data   = 32'h22;
    step();
    chk("pre_refresh_occ", {30'd0, occ_a}, 32'd2);
    refresh_a       = 1'b1;
    bus_a.out_ready = 1'b1;
    bus_a.in_data   = 32'hC;
    #1;
    chk("refresh_iready", {31'd0, bus_a.in_ready}, 32'd0);
    chk("refresh_ovalid", {31'd0, bus_a.out_valid}, 32'd0);
    step();
    refresh_a      = 1'b0;
    bus_a.in_valid = 1'b0;
    #1;
    chk("refresh_occ", {30'd0, occ_a}, 32'd0);
    chk("refresh_odata", bus_a.out_data, 32'd0);
    chk("refresh_ovalid2", {31'd0, bus_a.out_valid}, 32'd0);
    step();
    chk("refresh_no_c", {30'd0, occ_a}, 32'd0);

    // stall holds a single entry
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 32'h5;
    step();
    bus_a.in_valid  = 1'b0;
    stall_a         = 1'b1;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ovalid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("stall_iready", {31'd0, bus_a.in_ready}, 32'd0);
      step();
      chk("stall_data", bus_a.out_data, 32'h5);
      chk("stall_occ", {30'd0, occ_a}, 32'd1);
    end
    stall_a = 1'b0;
    #1;
    chk("unstall_ovalid", {31'd0, bus_a.out_valid}, 32'd1);
    chk("unstall_data", bus_a.out_data, 32'h5);
    step();
    chk("unstall_once", {30'd0, occ_a}, 32'd0);
    chk("unstall_ovalid0", {31'd0, bus_a.out_valid}, 32'd0);

    // asynchronous reset while FULL
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 32'h66;
    step();
    bus_a.in_data   = 32'h77;
    step();
    bus_a.in_valid  = 1'b0;
    chk("arst_pre_occ", {30'd0, occ_a}, 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_occ", {30'd0, occ_a}, 32'd0);
    chk("arst_ovalid", {31'd0, bus_a.out_valid}, 32'd0);
    chk("arst_odata", bus_a.out_data, 32'd0);
    chk("arst_iready", {31'd0, bus_a.in_ready}, 32'd0);
    #1;
    resetn = 1'b1;
    step();
    chk("arst_rel_iready", {31'd0, bus_a.in_ready}, 32'd1);
    chk("arst_rel_occ", {30'd0, occ_a}, 32'd0);

    // SKID=0 segment: combinational in_ready and perf counters
`ifdef SEG_PERF_EN
    chk("perf_full_init", pf_full_b, 32'd0);
    chk("perf_bub_init", pf_bub_b, 32'd0);
`endif
    bus_b.in_valid  = 1'b1;
    bus_b.in_data   = 32'h77;
    bus_b.out_ready = 1'b0;
    #1;
    chk("b_empty_iready", {31'd0, bus_b.in_ready}, 32'd1);
    step();
    bus_b.in_valid = 1'b0;
    #1;
    chk("b_one_iready_lo", {31'd0, bus_b.in_ready}, 32'd0);
    chk("b_one_ovalid", {31'd0, bus_b.out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("b_hold_data", bus_b.out_data, 32'h77);
    bus_b.out_ready = 1'b1;
    #1;
    chk("b_one_iready_hi", {31'd0, bus_b.in_ready}, 32'd1);
    step();
    chk("b_drain_occ", {30'd0, occ_b}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    bus_b.out_ready = 1'b0;
`ifdef SEG_PERF_EN
    chk("perf_full", pf_full_b, 32'd4);
    chk("perf_bubble", pf_bub_b, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
